host_mem_burst_splitter: RTL and testbench



---
 rtl/host_mem_split_pkg.sv | 28 ++
 rtl/host_mem_rd_resp_reg.sv | 23 ++
 rtl/host_mem_burst_splitter.sv | 229 ++++++++++++++++++++++
 tb/tb_host_mem_burst_splitter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_mem_split_pkg.sv
// rtl/host_mem_split_pkg.sv - shared state type and sub-burst length helper for the host memory burst splitter
package host_mem_split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } t_split_state;

  localparam int unsigned CALC_W = 32;

  // Longest legal sub-burst: limited by what is left, the room before the page edge and the cap.
  function automatic logic [CALC_W-1:0] calc_sub_len(
    input logic [CALC_W-1:0] addr_low,
    input logic [CALC_W-1:0] remaining,
    input logic [CALC_W-1:0] wpp,
    input logic [CALC_W-1:0] max_burst
  );
    logic [CALC_W-1:0] room;
    logic [CALC_W-1:0] len;
    room = wpp - addr_low;
    len  = remaining;
    if (room < len) len = room;
    if (max_burst < len) len = max_burst;
    return len;
  endfunction

endpackage

// File: rtl/host_mem_rd_resp_reg.sv
// rtl/host_mem_rd_resp_reg.sv - single register stage for read data and its valid strobe
module host_mem_rd_resp_reg #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/host_mem_burst_splitter.sv
// rtl/host_mem_burst_splitter.sv - splits Avalon-MM bursts into sub-bursts that stay inside a page and under a length cap
module host_mem_burst_splitter
  import host_mem_split_pkg::*;
#(
  parameter int ADDR_WIDTH      = 48,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int USER_WIDTH      = 8,
  parameter int PAGE_BYTES      = 4096,
  parameter int MAX_OUT_BURST   = 64
) (
  input  logic                       pClk,
  input  logic                       pClk_reset,
  input  logic [ADDR_WIDTH-1:0]      s_address,
  input  logic [BURST_CNT_WIDTH-1:0] s_burstcount,
  input  logic                       s_read,
  input  logic                       s_write,
  input  logic [DATA_WIDTH-1:0]      s_writedata,
  input  logic [DATA_WIDTH/8-1:0]    s_byteenable,
  input  logic [USER_WIDTH-1:0]      s_user,
  output logic                       s_waitrequest,
  output logic [DATA_WIDTH-1:0]      s_readdata,
  output logic                       s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]      m_address,
  output logic [BURST_CNT_WIDTH-1:0] m_burstcount,
  output logic                       m_read,
  output logic                       m_write,
  output logic [DATA_WIDTH-1:0]      m_writedata,
  output logic [DATA_WIDTH/8-1:0]    m_byteenable,
  output logic [USER_WIDTH-1:0]      m_user,
  input  logic                       m_waitrequest,
  input  logic [DATA_WIDTH-1:0]      m_readdata,
  input  logic                       m_readdatavalid,
  output logic [31:0]                split_count
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int WPP            = PAGE_BYTES / BYTES_PER_WORD;
  localparam int BC1            = BURST_CNT_WIDTH + 1;
  localparam logic [BC1-1:0] ONE = BC1'(1);

  if (PAGE_BYTES <= 0 || (PAGE_BYTES & (PAGE_BYTES - 1)) != 0) begin : g_chk_page
    $fatal(1, "host_mem_burst_splitter: PAGE_BYTES must be a power of two");
  end
  if (WPP < 1) begin : g_chk_wpp
    $fatal(1, "host_mem_burst_splitter: PAGE_BYTES smaller than one data word");
  end
  if (MAX_OUT_BURST < 1 || MAX_OUT_BURST > 2 ** (BURST_CNT_WIDTH - 1)) begin : g_chk_max
    $fatal(1, "host_mem_burst_splitter: MAX_OUT_BURST out of range");
  end

  t_split_state state_q, state_d;

  logic [ADDR_WIDTH-1:0]      m_address_d;
  logic [BURST_CNT_WIDTH-1:0] m_burstcount_d;
  logic                       m_read_d, m_write_d;
  logic [DATA_WIDTH-1:0]      m_writedata_d;
  logic [DATA_WIDTH/8-1:0]    m_byteenable_d;
  logic [USER_WIDTH-1:0]      m_user_d;

  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [BC1-1:0]        rem_q, rem_d;
  logic [BC1-1:0]        sub_left_q, sub_left_d;
  logic [BC1-1:0]        total_left_q, total_left_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic                  split_inc;

  logic                  out_free;
  logic [BC1-1:0]        bc_eff;
  logic [CALC_W-1:0]     s_low, n_low;
  logic [BC1-1:0]        s_len, n_len;

  assign out_free = ~(m_read | m_write) | ~m_waitrequest;
  assign bc_eff   = (s_burstcount == '0) ? ONE : {1'b0, s_burstcount};
  assign s_low    = CALC_W'(s_address & ADDR_WIDTH'(WPP - 1));
  assign n_low    = CALC_W'(next_addr_q & ADDR_WIDTH'(WPP - 1));
  assign s_len    = BC1'(calc_sub_len(s_low, CALC_W'(bc_eff), CALC_W'(WPP), CALC_W'(MAX_OUT_BURST)));
  assign n_len    = BC1'(calc_sub_len(n_low, CALC_W'(rem_q), CALC_W'(WPP), CALC_W'(MAX_OUT_BURST)));

  always_comb begin
    state_d        = state_q;
    m_address_d    = m_address;
    m_burstcount_d = m_burstcount;
    m_read_d       = m_read;
    m_write_d      = m_write;
    m_writedata_d  = m_writedata;
    m_byteenable_d = m_byteenable;
    m_user_d       = m_user;
    next_addr_d    = next_addr_q;
    rem_d          = rem_q;
    sub_left_d     = sub_left_q;
    total_left_d   = total_left_q;
    user_d         = user_q;
    split_inc      = 1'b0;
    s_waitrequest  = ~out_free;

    case (state_q)
      IDLE: begin
        if (out_free) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          // Write wins when both strobes are raised together.
          if (s_write) begin
            m_write_d      = 1'b1;
            m_address_d    = s_address;
            m_burstcount_d = BURST_CNT_WIDTH'(s_len);
            m_writedata_d  = s_writedata;
            m_byteenable_d = s_byteenable;
            m_user_d       = s_user;
            user_d         = s_user;
            next_addr_d    = s_address + ADDR_WIDTH'(s_len);
            rem_d          = bc_eff - s_len;
            sub_left_d     = s_len - ONE;
            total_left_d   = bc_eff - ONE;
            if (bc_eff > ONE) state_d = WR;
          end else if (s_read) begin
            m_read_d       = 1'b1;
            m_address_d    = s_address;
            m_burstcount_d = BURST_CNT_WIDTH'(s_len);
            m_user_d       = s_user;
            user_d         = s_user;
            next_addr_d    = s_address + ADDR_WIDTH'(s_len);
            rem_d          = bc_eff - s_len;
            if (s_len < bc_eff) state_d = RD;
          end
        end
      end

      RD: begin
        s_waitrequest = 1'b1;
        if (out_free) begin
          m_read_d       = 1'b1;
          m_write_d      = 1'b0;
          m_address_d    = next_addr_q;
          m_burstcount_d = BURST_CNT_WIDTH'(n_len);
          m_user_d       = user_q;
          next_addr_d    = next_addr_q + ADDR_WIDTH'(n_len);
          rem_d          = rem_q - n_len;
          split_inc      = 1'b1;
          if (rem_q == n_len) state_d = IDLE;
        end
      end

      WR: begin
        if (out_free) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          if (s_write) begin
            m_write_d      = 1'b1;
            m_writedata_d  = s_writedata;
            m_byteenable_d = s_byteenable;
            m_user_d       = user_q;
            total_left_d   = total_left_q - ONE;
            // A beat arriving with the current sub-burst exhausted opens the next one.
            if (sub_left_q == '0) begin
              m_address_d    = next_addr_q;
              m_burstcount_d = BURST_CNT_WIDTH'(n_len);
              next_addr_d    = next_addr_q + ADDR_WIDTH'(n_len);
              rem_d          = rem_q - n_len;
              sub_left_d     = n_len - ONE;
              split_inc      = 1'b1;
            end else begin
              sub_left_d = sub_left_q - ONE;
            end
            if (total_left_q == ONE) state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (pClk_reset) s_waitrequest = 1'b1;
  end

  always_ff @(posedge pClk or posedge pClk_reset) begin
    if (pClk_reset) begin
      state_q      <= IDLE;
      m_address    <= '0;
      m_burstcount <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
      m_user       <= '0;
      next_addr_q  <= '0;
      rem_q        <= '0;
      sub_left_q   <= '0;
      total_left_q <= '0;
      user_q       <= '0;
      split_count  <= '0;
    end else begin
      state_q      <= state_d;
      m_address    <= m_address_d;
      m_burstcount <= m_burstcount_d;
      m_read       <= m_read_d;
      m_write      <= m_write_d;
      m_writedata  <= m_writedata_d;
      m_byteenable <= m_byteenable_d;
      m_user       <= m_user_d;
      next_addr_q  <= next_addr_d;
      rem_q        <= rem_d;
      sub_left_q   <= sub_left_d;
      total_left_q <= total_left_d;
      user_q       <= user_d;
      if (split_inc && split_count != 32'hFFFF_FFFF) split_count <= split_count + 32'd1;
    end
  end

  host_mem_rd_resp_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_resp (
    .clk      (pClk),
    .rst      (pClk_reset),
    .in_data  (m_readdata),
    .in_valid (m_readdatavalid),
    .out_data (s_readdata),
    .out_valid(s_readdatavalid)
  );

  always @(posedge pClk) begin
    if (!pClk_reset) begin
      assert (!(s_read && s_write));
      assert (!(state_q == WR && s_read));
      assert (!(state_q == IDLE && out_free && (s_read || s_write) && s_burstcount == '0));
    end
  end

endmodule

// File: tb/tb_host_mem_burst_splitter.sv
// tb/tb_host_mem_burst_splitter.sv - randomized and directed bench for host_mem_burst_splitter against a page/cap split model
`timescale 1ns/1ps
module tb_host_mem_burst_splitter;

  localparam int AW = 48, DW = 512, BCW = 7, UW = 8, PB = 4096, MOB = 16;
  localparam int WPP = PB / (DW / 8);

  typedef struct {
    bit              is_wr;
    longint unsigned addr;
    int              bc;
    int              user;
  } cmd_t;

  logic           pClk = 1'b0;
  logic           pClk_reset = 1'b1;
  logic [AW-1:0]  s_address = '0;
  logic [BCW-1:0] s_burstcount = '0;
  logic           s_read = 1'b0, s_write = 1'b0;
  logic [DW-1:0]  s_writedata = '0;
  logic [DW/8-1:0] s_byteenable = '0;
  logic [UW-1:0]  s_user = '0;
  logic           s_waitrequest, s_readdatavalid;
  logic [DW-1:0]  s_readdata;
  logic [AW-1:0]  m_address;
  logic [BCW-1:0] m_burstcount;
  logic           m_read, m_write;
  logic [DW-1:0]  m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic [UW-1:0]  m_user;
  logic           m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [DW-1:0]  m_readdata = '0;
  logic [31:0]    split_count;

  host_mem_burst_splitter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .USER_WIDTH(UW),
    .PAGE_BYTES(PB), .MAX_OUT_BURST(MOB)
  ) dut (
    .pClk(pClk), .pClk_reset(pClk_reset),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_user(s_user),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable), .m_user(m_user),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .split_count(split_count)
  );

  always #5 pClk = ~pClk;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  longint split_model = 0;
  bit stall_force = 0, rand_wait = 0;

  cmd_t            exp_cmd[$];
  logic [DW-1:0]   exp_rdata[$];
  logic [DW-1:0]   exp_wdata[$];
  logic [DW/8-1:0] exp_wbe[$];
  logic [AW-1:0]   slv_rd[$];
  int              cmd_cyc[$];

  int              wr_left = 0;
  cmd_t            cur;
  bit              prev_stall = 0;
  logic [AW-1:0]   snap_addr;
  logic [BCW-1:0]  snap_bc;
  logic            snap_rd, snap_wr;
  logic [DW-1:0]   snap_wd;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {8{{16'hA5A5, a}}};
  endfunction

  // Reference split: walk the burst, cutting at page edges and at the length cap.
  task automatic plan(input bit is_wr, input longint unsigned addr, input int bc, input int user,
                      output int n);
    longint unsigned a;
    int r, room, len;
    a = addr; r = bc; n = 0;
    while (r > 0) begin
      room = WPP - int'(a % WPP);
      len  = r;
      if (room < len) len = room;
      if (MOB < len) len = MOB;
      exp_cmd.push_back('{is_wr, a, len, user});
      a += len; r -= len; n++;
    end
  endtask

  task automatic flush();
    exp_cmd.delete(); exp_rdata.delete(); exp_wdata.delete(); exp_wbe.delete(); slv_rd.delete();
    wr_left = 0; split_model = 0; prev_stall = 0;
  endtask

  initial forever begin
    @(posedge pClk);
    cyc++;
  end

  // Downstream slave: waitrequest and in-order read data
  initial forever begin
    @(posedge pClk);
    #1;
    if (pClk_reset) begin
      m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0; slv_rd.delete();
    end else begin
      m_waitrequest = stall_force || (rand_wait && $urandom_range(0, 3) == 0);
      if (slv_rd.size() > 0 && (!rand_wait || $urandom_range(0, 3) != 0)) begin
        m_readdatavalid = 1'b1;
        m_readdata = pat(slv_rd.pop_front());
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata = '0;
      end
    end
  end

  // Monitor: downstream transfers, hold-under-stall, upstream read data
  initial forever begin
    cmd_t e;
    @(negedge pClk);
    if (pClk_reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("hold_addr", m_address, snap_addr);
        check("hold_bc", m_burstcount, snap_bc);
        check("hold_rd", m_read, snap_rd);
        check("hold_wr", m_write, snap_wr);
        check("hold_wdata", m_writedata, snap_wd);
      end
      prev_stall = (m_read || m_write) && m_waitrequest;
      if (prev_stall) check("stall_swait", s_waitrequest, 1);
      snap_addr = m_address; snap_bc = m_burstcount; snap_rd = m_read; snap_wr = m_write;
      snap_wd = m_writedata;
      if ((m_read || m_write) && !m_waitrequest) begin
        cmd_cyc.push_back(cyc);
        if (m_read || wr_left == 0) begin
          if (exp_cmd.size() == 0) begin
            check("cmd_extra", 1, 0);
          end else begin
            e = exp_cmd.pop_front();
            check("cmd_kind", m_write, e.is_wr);
            check("cmd_addr", m_address, e.addr);
            check("cmd_bc", m_burstcount, e.bc);
            check("cmd_user", m_user, e.user);
            cur = e;
            if (m_write) wr_left = int'(m_burstcount);
          end
        end else begin
          check("wr_hold_addr", m_address, cur.addr);
          check("wr_hold_bc", m_burstcount, cur.bc);
        end
        if (m_read) begin
          for (int i = 0; i < int'(m_burstcount); i++) slv_rd.push_back(m_address + AW'(i));
        end else begin
          if (exp_wdata.size() == 0) check("wdata_extra", 1, 0);
          else begin
            check("wdata", m_writedata, exp_wdata.pop_front());
            check("wbe", m_byteenable, exp_wbe.pop_front());
          end
          if (wr_left > 0) wr_left--;
        end
      end
      if (s_readdatavalid) begin
        if (exp_rdata.size() == 0) check("rdata_extra", 1, 0);
        else check("rdata", s_readdata, exp_rdata.pop_front());
      end
    end
  end

  task automatic do_read(input logic [AW-1:0] addr, input int bc, input logic [UW-1:0] user);
    int n, g;
    plan(1'b0, longint'(addr), bc, int'(user), n);
    split_model += n - 1;
    for (int i = 0; i < bc; i++) exp_rdata.push_back(pat(addr + AW'(i)));
    s_read = 1'b1; s_address = addr; s_burstcount = BCW'(bc); s_user = user;
    g = 0;
    #1;
    while (s_waitrequest && g < 500) begin
      @(negedge pClk); #1; g++;
    end
    if (g >= 500) check("rd_accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(negedge pClk);
    s_read = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int bc, input logic [UW-1:0] user,
                          input bit gaps, input int abort_at, output int stalls);
    int n, g;
    logic [DW-1:0] d;
    logic [DW/8-1:0] be;
    stalls = 0;
    plan(1'b1, longint'(addr), bc, int'(user), n);
    split_model += n - 1;
    for (int b = 0; b < bc; b++) begin
      if (b == abort_at) begin
        check("pre_rst_m_write", m_write, 1);
        pClk_reset = 1'b1;
        #1;
        check("rst_m_write", m_write, 0);
        check("rst_m_read", m_read, 0);
        check("rst_swait", s_waitrequest, 1);
        check("rst_split", split_count, 0);
        s_write = 1'b0;
        flush();
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_write = 1'b0;
        @(negedge pClk);
      end
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      be = {$urandom, $urandom};
      s_write = 1'b1; s_address = addr; s_burstcount = BCW'(bc); s_user = user;
      s_writedata = d; s_byteenable = be;
      g = 0;
      #1;
      while (s_waitrequest && g < 500) begin
        @(negedge pClk); #1; g++; stalls++;
      end
      if (g >= 500) check("wr_accept_timeout", 0, 1);
      exp_wdata.push_back(d); exp_wbe.push_back(be);
      @(negedge pClk);
    end
    s_write = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while ((exp_cmd.size() > 0 || exp_rdata.size() > 0 || exp_wdata.size() > 0) && g < 3000) begin
      @(negedge pClk); g++;
    end
    check({tag, "_drain_left"}, exp_cmd.size() + exp_rdata.size() + exp_wdata.size(), 0);
    repeat (3) @(negedge pClk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [AW-1:0] a;
    repeat (3) @(negedge pClk);
    check("reset_swait", s_waitrequest, 1);
    check("reset_m_read", m_read, 0);
    check("reset_m_write", m_write, 0);
    check("reset_rdv", s_readdatavalid, 0);
    check("reset_split", split_count, 0);
    pClk_reset = 1'b0;
    @(negedge pClk);
    check("idle_swait", s_waitrequest, 0);

    cmd_cyc.delete();
    do_read(48'h10, 8, 8'h11);
    drain("t1");
    check("t1_nsub", cmd_cyc.size(), 1);
    check("t1_latency", cmd_cyc[0], acc_cyc + 1);
    check("t1_split", split_count, 0);

    cmd_cyc.delete();
    do_read(48'h3C, 10, 8'h22);
    drain("t2");
    check("t2_nsub", cmd_cyc.size(), 2);
    check("t2_gap", cmd_cyc[1] - cmd_cyc[0], 1);
    check("t2_split", split_count, 1);

    cmd_cyc.delete();
    do_write(48'h7E, 4, 8'h33, 1'b0, -1, st);
    drain("t3");
    check("t3_stalls", st, 0);
    check("t3_beats", cmd_cyc.size(), 4);
    check("t3_span", cmd_cyc[3] - cmd_cyc[0], 3);
    check("t3_split", split_count, 2);

    cmd_cyc.delete();
    do_read(48'h0, 64, 8'h44);
    drain("t4");
    check("t4_nsub", cmd_cyc.size(), 4);
    check("t4_span", cmd_cyc[3] - cmd_cyc[0], 3);
    check("t4_split", split_count, 5);

    stall_force = 1;
    @(negedge pClk);
    do_read(48'h3C, 10, 8'h55);
    repeat (5) begin
      check("t5_rd_swait", s_waitrequest, 1);
      check("t5_rd_addr", m_address, 48'h3C);
      check("t5_rd_bc", m_burstcount, 4);
      @(negedge pClk);
    end
    stall_force = 0;
    drain("t5r");
    fork
      do_write(48'h7E, 8, 8'h66, 1'b0, -1, st);
      begin
        repeat (3) @(negedge pClk);
        stall_force = 1;
        repeat (5) @(negedge pClk);
        stall_force = 0;
      end
    join
    drain("t5w");
    check("t5_split", split_count, 7);

    do_write(48'h100, 8, 8'h77, 1'b0, 2, st);
    repeat (3) @(negedge pClk);
    pClk_reset = 1'b0;
    @(negedge pClk);
    check("t6_idle_swait", s_waitrequest, 0);
    check("t6_split_clear", split_count, 0);
    do_read(48'h0, 1, 8'h88);
    drain("t6");
    check("t6_split", split_count, 0);

    rand_wait = 1;
    for (int n = 0; n < 40; n++) begin
      a = AW'(longint'($urandom_range(0, 4095)) * WPP);
      if ($urandom_range(0, 1) == 0) a = a + AW'(WPP - $urandom_range(1, 20));
      else a = a + AW'($urandom_range(0, WPP - 1));
      if ($urandom_range(0, 1) == 0)
        do_read(a, $urandom_range(1, 127), UW'($urandom));
      else
        do_write(a, $urandom_range(1, 127), UW'($urandom), 1'b1, -1, st);
    end
    drain("rand");
    check("rand_split", split_count, split_model[31:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
